// File: rtl/i2cs_core_if.sv
// i2cs_core_if -- register-bus side of the I2C slave engine.
//
// Groups the byte-level write/read handshake between the I2C slave core and
// the local register block.
//   master modport : used by i2cs_core (issues write pulses and read requests)
//   slave  modport : used by the register block (supplies read data/ack)
// Signals:
//   wr_valid  one-cycle pulse, wr_offset/wr_data hold a received byte
//   rd_req    one-cycle pulse, fetch the byte at rd_offset
//   rd_data   read byte returned by the register block
//   rd_ack    read data valid (only used when clock stretching is built in)
`timescale 1ns/1ps
interface i2cs_core_if;
    logic       wr_valid;
    logic [7:0] wr_offset;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_offset;
    logic [7:0] rd_data;
    logic       rd_ack;

    modport master (
        output wr_valid, wr_offset, wr_data, rd_req, rd_offset,
        input  rd_data, rd_ack
    );

    modport slave (
        input  wr_valid, wr_offset, wr_data, rd_req, rd_offset,
        output rd_data, rd_ack
    );
endinterface

// File: rtl/i2cs_core.sv
// i2cs_core -- I2C slave engine with 7-bit address match, one-byte
// auto-incrementing register offset and a register-bus byte interface.
//
// Ports:
//   sys_clk, sys_rst      clock, asynchronous active-low reset
//   slave_id[6:0]         device address to match (0 = general call, never matched)
//   io_scl_in/io_sda_in   pad inputs
//   io_scl_out/io_sda_out tied 0 (open drain)
//   io_scl_oe             1 = pull SCL low (clock stretch only)
//   io_sda_oe             1 = pull SDA low
//   reg_bus               i2cs_core_if.master: write pulses and read requests
//   busy                  1 from a matched address until STOP or Sr
//   start_det/stop_det    one-cycle pulses on START/Sr and STOP
//
// Parameter HOLD_CYC (2..15): cycles from a detected SCL falling edge until
// the core changes SDA.
//
// Build option: define I2CS_STRETCH_EN to hold SCL low after each read
// request until the register block answers with rd_ack. Without it SCL is
// never driven and rd_data is captured one cycle after rd_req.
`timescale 1ns/1ps
module i2cs_core #(
    parameter int HOLD_CYC = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [6:0]  slave_id,
    input  logic        io_scl_in,
    input  logic        io_sda_in,
    output logic        io_scl_out,
    output logic        io_scl_oe,
    output logic        io_sda_out,
    output logic        io_sda_oe,
    i2cs_core_if.master reg_bus,
    output logic        busy,
    output logic        start_det,
    output logic        stop_det
);

    localparam logic [3:0] HOLD = HOLD_CYC[3:0];

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        IGNORE,
        OFFS,
        OFFS_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_P
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: 2-flop synchronizer plus 1-flop history per line
    // ------------------------------------------------------------------
    logic scl_meta_reg, scl_sync_reg, scl_hist_reg;
    logic sda_meta_reg, sda_sync_reg, sda_hist_reg;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            scl_meta_reg <= 1'b1;
            scl_sync_reg <= 1'b1;
            scl_hist_reg <= 1'b1;
            sda_meta_reg <= 1'b1;
            sda_sync_reg <= 1'b1;
            sda_hist_reg <= 1'b1;
        end else begin
            scl_meta_reg <= io_scl_in;
            scl_sync_reg <= scl_meta_reg;
            scl_hist_reg <= scl_sync_reg;
            sda_meta_reg <= io_sda_in;
            sda_sync_reg <= sda_meta_reg;
            sda_hist_reg <= sda_sync_reg;
        end
    end

    logic scl_rise, scl_fall, start_cond, stop_cond, hold_fire, drive_ok;
    logic [7:0] rx_byte;

    assign scl_rise   = scl_sync_reg & ~scl_hist_reg;
    assign scl_fall   = ~scl_sync_reg & scl_hist_reg;
    // SCL must be high in both the current and previous sample, so an SDA
    // change that lands in the same cycle as an SCL release is not mistaken
    // for START/STOP.
    assign start_cond = scl_sync_reg & scl_hist_reg & sda_hist_reg & ~sda_sync_reg;
    assign stop_cond  = scl_sync_reg & scl_hist_reg & ~sda_hist_reg & sda_sync_reg;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [6:0] rx_reg, rx_next;
    logic [7:0] tx_reg, tx_next;
    logic [7:0] offset_reg, offset_next;
    logic       rw_reg, rw_next;
    logic       ack_phase_reg, ack_phase_next;   // 1 while in the ACK bit itself
    logic       mack_reg, mack_next;             // master ACK sampled after a read byte
    logic       sda_oe_reg, sda_oe_next;
    logic       busy_reg, busy_next;
    logic       wr_valid_reg, wr_valid_next;
    logic [7:0] wr_offset_reg, wr_offset_next;
    logic [7:0] wr_data_reg, wr_data_next;
    logic       rd_req_reg, rd_req_next;
    logic [7:0] rd_offset_reg, rd_offset_next;
    logic       start_det_reg, start_det_next;
    logic       stop_det_reg, stop_det_next;
    logic       inc_pend_reg, inc_pend_next;     // offset bump one cycle after wr_valid
    logic [3:0] hold_cnt_reg, hold_cnt_next;
`ifdef I2CS_STRETCH_EN
    logic       scl_oe_reg, scl_oe_next;
    logic       wait_ack_reg, wait_ack_next;
`endif

    assign hold_fire = (hold_cnt_reg == 4'd1);
    assign rx_byte   = {rx_reg, sda_sync_reg};

`ifdef I2CS_STRETCH_EN
    // While waiting for rd_ack the shift register is stale; do not drive it.
    assign drive_ok = hold_fire & ~wait_ack_reg;
`else
    assign drive_ok = hold_fire;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            rx_reg        <= 7'd0;
            tx_reg        <= 8'd0;
            offset_reg    <= 8'd0;
            rw_reg        <= 1'b0;
            ack_phase_reg <= 1'b0;
            mack_reg      <= 1'b0;
            sda_oe_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            wr_valid_reg  <= 1'b0;
            wr_offset_reg <= 8'd0;
            wr_data_reg   <= 8'd0;
            rd_req_reg    <= 1'b0;
            rd_offset_reg <= 8'd0;
            start_det_reg <= 1'b0;
            stop_det_reg  <= 1'b0;
            inc_pend_reg  <= 1'b0;
            hold_cnt_reg  <= 4'd0;
`ifdef I2CS_STRETCH_EN
            scl_oe_reg    <= 1'b0;
            wait_ack_reg  <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_reg        <= rx_next;
            tx_reg        <= tx_next;
            offset_reg    <= offset_next;
            rw_reg        <= rw_next;
            ack_phase_reg <= ack_phase_next;
            mack_reg      <= mack_next;
            sda_oe_reg    <= sda_oe_next;
            busy_reg      <= busy_next;
            wr_valid_reg  <= wr_valid_next;
            wr_offset_reg <= wr_offset_next;
            wr_data_reg   <= wr_data_next;
            rd_req_reg    <= rd_req_next;
            rd_offset_reg <= rd_offset_next;
            start_det_reg <= start_det_next;
            stop_det_reg  <= stop_det_next;
            inc_pend_reg  <= inc_pend_next;
            hold_cnt_reg  <= hold_cnt_next;
`ifdef I2CS_STRETCH_EN
            scl_oe_reg    <= scl_oe_next;
            wait_ack_reg  <= wait_ack_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        rx_next        = rx_reg;
        tx_next        = tx_reg;
        offset_next    = offset_reg;
        rw_next        = rw_reg;
        ack_phase_next = ack_phase_reg;
        mack_next      = mack_reg;
        sda_oe_next    = sda_oe_reg;
        busy_next      = busy_reg;
        wr_valid_next  = 1'b0;
        wr_offset_next = wr_offset_reg;
        wr_data_next   = wr_data_reg;
        rd_req_next    = 1'b0;
        rd_offset_next = rd_offset_reg;
        start_det_next = 1'b0;
        stop_det_next  = 1'b0;
        inc_pend_next  = 1'b0;
        hold_cnt_next  = hold_cnt_reg;
`ifdef I2CS_STRETCH_EN
        scl_oe_next    = scl_oe_reg;
        wait_ack_next  = wait_ack_reg;
`endif

        // Hold timer: restarted on every SCL fall, SDA updates when it expires.
        if (scl_fall) begin
            hold_cnt_next = HOLD;
        end else if (hold_cnt_reg != 4'd0) begin
            hold_cnt_next = hold_cnt_reg - 4'd1;
        end

        if (inc_pend_reg) begin
            offset_next = offset_reg + 8'd1;
        end

        // SDA value for the bit that starts after this falling edge.
        if (drive_ok) begin
            case (state_reg)
                ADDR_ACK, OFFS_ACK, WDATA_ACK: sda_oe_next = ack_phase_reg;
                RDATA:                         sda_oe_next = ~tx_reg[7];
                default:                       sda_oe_next = 1'b0;
            endcase
        end

        // Read data capture.
`ifdef I2CS_STRETCH_EN
        if (wait_ack_reg && reg_bus.rd_ack) begin
            tx_next       = reg_bus.rd_data;
            wait_ack_next = 1'b0;
            scl_oe_next   = 1'b0;
            // If the hold time already elapsed while SCL was stretched, put
            // the first bit on SDA now, before SCL can rise.
            if (hold_cnt_reg <= 4'd1) begin
                sda_oe_next = ~reg_bus.rd_data[7];
            end
        end
`else
        if (rd_req_reg) begin
            tx_next = reg_bus.rd_data;
        end
`endif

        if (start_cond) begin
            state_next     = ADDR;
            bit_cnt_next   = 3'd0;
            sda_oe_next    = 1'b0;
            busy_next      = 1'b0;
            ack_phase_next = 1'b0;
            start_det_next = 1'b1;
`ifdef I2CS_STRETCH_EN
            scl_oe_next    = 1'b0;
            wait_ack_next  = 1'b0;
`endif
        end else if (stop_cond) begin
            state_next     = IDLE;
            bit_cnt_next   = 3'd0;
            sda_oe_next    = 1'b0;
            busy_next      = 1'b0;
            ack_phase_next = 1'b0;
            stop_det_next  = 1'b1;
`ifdef I2CS_STRETCH_EN
            scl_oe_next    = 1'b0;
            wait_ack_next  = 1'b0;
`endif
        end else begin
            case (state_reg)
                ADDR, OFFS, WDATA: begin
                    if (scl_rise) begin
                        rx_next      = rx_byte[6:0];
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            bit_cnt_next = 3'd0;
                            if (state_reg == ADDR) begin
                                if (rx_byte[7:1] == slave_id && rx_byte[7:1] != 7'd0) begin
                                    state_next = ADDR_ACK;
                                    rw_next    = rx_byte[0];
                                    busy_next  = 1'b1;
                                end else begin
                                    state_next = IGNORE;
                                end
                            end else if (state_reg == OFFS) begin
                                offset_next = rx_byte;
                                state_next  = OFFS_ACK;
                            end else begin
                                wr_valid_next  = 1'b1;
                                wr_offset_next = offset_reg;
                                wr_data_next   = rx_byte;
                                inc_pend_next  = 1'b1;
                                state_next     = WDATA_ACK;
                            end
                        end
                    end
                end

                // First fall ends the 8th bit and opens the ACK bit; the
                // second fall closes the ACK bit.
                ADDR_ACK, OFFS_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_reg) begin
                            ack_phase_next = 1'b1;
                        end else begin
                            ack_phase_next = 1'b0;
                            bit_cnt_next   = 3'd0;
                            if (state_reg == ADDR_ACK && rw_reg) begin
                                state_next     = RDATA;
                                rd_req_next    = 1'b1;
                                rd_offset_next = offset_reg;
`ifdef I2CS_STRETCH_EN
                                scl_oe_next    = 1'b1;
                                wait_ack_next  = 1'b1;
`endif
                            end else if (state_reg == ADDR_ACK) begin
                                state_next = OFFS;
                            end else begin
                                state_next = WDATA;
                            end
                        end
                    end
                end

                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_reg == 3'd7) begin
                            bit_cnt_next = 3'd0;
                            offset_next  = offset_reg + 8'd1;
                            state_next   = RDATA_ACK;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 3'd1;
                            tx_next      = {tx_reg[6:0], 1'b0};
                        end
                    end
                end

                RDATA_ACK: begin
                    if (scl_rise) begin
                        mack_next = sda_sync_reg;
                    end
                    if (scl_fall) begin
                        if (!mack_reg) begin
                            state_next     = RDATA;
                            bit_cnt_next   = 3'd0;
                            rd_req_next    = 1'b1;
                            rd_offset_next = offset_reg;
`ifdef I2CS_STRETCH_EN
                            scl_oe_next    = 1'b1;
                            wait_ack_next  = 1'b1;
`endif
                        end else begin
                            state_next = WAIT_P;
                        end
                    end
                end

                default: begin
                    // IDLE, IGNORE, WAIT_P: only START/STOP move on.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign io_scl_out = 1'b0;
    assign io_sda_out = 1'b0;
    assign io_sda_oe  = sda_oe_reg;
`ifdef I2CS_STRETCH_EN
    assign io_scl_oe  = scl_oe_reg;
`else
    assign io_scl_oe  = 1'b0;
`endif

    assign busy      = busy_reg;
    assign start_det = start_det_reg;
    assign stop_det  = stop_det_reg;

    assign reg_bus.wr_valid  = wr_valid_reg;
    assign reg_bus.wr_offset = wr_offset_reg;
    assign reg_bus.wr_data   = wr_data_reg;
    assign reg_bus.rd_req    = rd_req_reg;
    assign reg_bus.rd_offset = rd_offset_reg;

endmodule

// File: tb/tb_i2cs_core.sv
// tb_i2cs_core -- directed bench for i2cs_core with a bit-level I2C host
// model, an open-drain bus model and a write/read scoreboard.
`timescale 1ns/1ps
module tb_i2cs_core;
    localparam int Q = 10;   // quarter SCL period in sys_clk cycles

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] slave_id = 7'h50;
    logic host_scl = 1'b1;
    logic host_sda = 1'b1;
    logic io_scl_out, io_scl_oe, io_sda_out, io_sda_oe;
    logic busy, start_det, stop_det;

    wire scl_line = host_scl & ~io_scl_oe;
    wire sda_line = host_sda & ~io_sda_oe;

    i2cs_core_if bus();

    i2cs_core #(.HOLD_CYC(4)) dut (
        .sys_clk    (clk),
        .sys_rst    (rst_n),
        .slave_id   (slave_id),
        .io_scl_in  (scl_line),
        .io_sda_in  (sda_line),
        .io_scl_out (io_scl_out),
        .io_scl_oe  (io_scl_oe),
        .io_sda_out (io_sda_out),
        .io_sda_oe  (io_sda_oe),
        .reg_bus    (bus),
        .busy       (busy),
        .start_det  (start_det),
        .stop_det   (stop_det)
    );

    // Register model: byte at offset o reads as o ^ 0xFF.
    assign bus.rd_data = bus.rd_offset ^ 8'hFF;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int stop_cnt = 0;
    int scl_oe_seen = 0;
    int stretch_runs = 0;
    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    // rd_ack answers 20 cycles after each rd_req (ignored unless stretching).
    initial begin
        bus.rd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rd_req) begin
                repeat (20) @(negedge clk);
                bus.rd_ack = 1'b1;
                @(negedge clk);
                bus.rd_ack = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a transfer.
    int scl_run = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_valid) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr actual=%0h_%0h required=none", bus.wr_offset, bus.wr_data);
                end else begin
                    chk("wr_offset_data", {bus.wr_offset, bus.wr_data}, exp_wr_q.pop_front());
                end
            end
            if (bus.rd_req) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rd actual=%0h required=none", bus.rd_offset);
                end else begin
                    chk("rd_offset", {8'h00, bus.rd_offset}, {8'h00, exp_rd_q.pop_front()});
                end
            end
            if (start_det) start_cnt++;
            if (stop_det) stop_cnt++;
            if (io_scl_oe) begin
                scl_oe_seen = 1;
                scl_run++;
            end else if (scl_run != 0) begin
                stretch_runs++;
                chk("scl_stretch_len", 16'(scl_run), 16'd21);
                scl_run = 0;
            end
        end
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic scl_up();
        int n;
        host_scl = 1'b1;
        n = 0;
        while (!scl_line && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!scl_line) begin
            checks++;
            errors++;
            $display("FAIL scl_release_timeout actual=0 required=1");
        end
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        host_sda = b;
        wq();
        scl_up();
        wq();
        r = sda_line;
        wq();
        host_scl = 1'b0;
        wq();
    endtask

    // Works as START from idle and as Sr with SCL low.
    task automatic i2c_start();
        host_sda = 1'b1;
        wq();
        scl_up();
        wq();
        host_sda = 1'b0;
        wq();
        host_scl = 1'b0;
        wq();
    endtask

    task automatic i2c_stop();
        host_sda = 1'b0;
        wq();
        scl_up();
        wq();
        host_sda = 1'b1;
        wq();
        wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], d);
        xfer_bit(1'b1, ack);
    endtask

    task automatic wr_acked(input string name, input logic [7:0] b);
        logic a;
        write_byte(b, a);
        chk(name, {15'd0, a}, 16'd0);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic x;
        for (int i = 7; i >= 0; i--) xfer_bit(1'b1, d[i]);
        xfer_bit(mack, x);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic a, x;
        int s0;

        repeat (5) @(negedge clk);
        chk("rst_sda_oe", {15'd0, io_sda_oe}, 16'd0);
        chk("rst_scl_oe", {15'd0, io_scl_oe}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_wr_valid", {15'd0, bus.wr_valid}, 16'd0);
        chk("rst_rd_req", {15'd0, bus.rd_req}, 16'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: write three bytes from offset 0x10
        exp_wr_q.push_back(16'h1011);
        exp_wr_q.push_back(16'h1122);
        exp_wr_q.push_back(16'h1233);
        i2c_start();
        wr_acked("t1_addr_ack", 8'hA0);
        wr_acked("t1_offs_ack", 8'h10);
        wr_acked("t1_d0_ack", 8'h11);
        wr_acked("t1_d1_ack", 8'h22);
        wr_acked("t1_d2_ack", 8'h33);
        chk("t1_busy", {15'd0, busy}, 16'd1);
        i2c_stop();
        chk("t1_stop_cnt", 16'(stop_cnt), 16'd1);
        chk("t1_busy_after_p", {15'd0, busy}, 16'd0);

        // 2: read two bytes continuing at offset 0x13
        exp_rd_q.push_back(8'h13);
        exp_rd_q.push_back(8'h14);
        i2c_start();
        wr_acked("t2_addr_ack", 8'hA1);
        read_byte(1'b0, d);
        chk("t2_rd0", {8'h00, d}, 16'h00EC);
        read_byte(1'b1, d);
        chk("t2_rd1", {8'h00, d}, 16'h00EB);
        wq();
        chk("t2_sda_released", {15'd0, io_sda_oe}, 16'd0);
        i2c_stop();

        // 3: foreign address is ignored
        i2c_start();
        write_byte(8'hA2, a);
        chk("t3_addr_nack", {15'd0, a}, 16'd1);
        chk("t3_busy", {15'd0, busy}, 16'd0);
        write_byte(8'h10, a);
        chk("t3_data_nack", {15'd0, a}, 16'd1);
        i2c_stop();

        // 4: offset wraps 0xFF -> 0x00
        exp_wr_q.push_back(16'hFEAA);
        exp_wr_q.push_back(16'hFFBB);
        exp_wr_q.push_back(16'h00CC);
        i2c_start();
        wr_acked("t4_addr_ack", 8'hA0);
        wr_acked("t4_offs_ack", 8'hFE);
        wr_acked("t4_d0_ack", 8'hAA);
        wr_acked("t4_d1_ack", 8'hBB);
        wr_acked("t4_d2_ack", 8'hCC);
        i2c_stop();

        // 5a: set offset, repeated start, read one byte
        s0 = start_cnt;
        exp_rd_q.push_back(8'h05);
        i2c_start();
        wr_acked("t5_addr_ack", 8'hA0);
        wr_acked("t5_offs_ack", 8'h05);
        i2c_start();
        wr_acked("t5_sr_addr_ack", 8'hA1);
        read_byte(1'b1, d);
        chk("t5_rd", {8'h00, d}, 16'h00FA);
        i2c_stop();
        chk("t5_start_pulses", 16'(start_cnt - s0), 16'd2);

        // 5b: STOP after four data bits discards the byte
        i2c_start();
        wr_acked("t5b_addr_ack", 8'hA0);
        wr_acked("t5b_offs_ack", 8'h20);
        for (int i = 0; i < 4; i++) xfer_bit(1'b1, x);
        i2c_stop();
        chk("t5b_busy", {15'd0, busy}, 16'd0);

        // back from IDLE: a normal write still works
        exp_wr_q.push_back(16'h3044);
        i2c_start();
        wr_acked("t5c_addr_ack", 8'hA0);
        wr_acked("t5c_offs_ack", 8'h30);
        wr_acked("t5c_d0_ack", 8'h44);
        i2c_stop();

        repeat (50) @(negedge clk);
        chk("wr_queue_drained", 16'(exp_wr_q.size()), 16'd0);
        chk("rd_queue_drained", 16'(exp_rd_q.size()), 16'd0);
        chk("stop_total", 16'(stop_cnt), 16'd7);
`ifdef I2CS_STRETCH_EN
        chk("stretch_runs", 16'(stretch_runs), 16'd3);
`else
        chk("scl_oe_never", 16'(scl_oe_seen), 16'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
